load_miss_handler: RTL and testbench

- Miss-status holding block that sits between the load queue and the shared memory port.
- Accepts load-miss block addresses, issues a LOAD request for each one to memory, and tracks the returned memory tags.
- When memory answers, it broadcasts the fill on the lq_miss_valid / lq_miss_addr / lq_miss_data bus that the load queue snoops.
- It is the producer (responder) side of that miss-fill interface.

---
 rtl/load_miss_handler.sv | 154 +++++++++++++++
 tb/tb_load_miss_handler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_miss_handler.sv
// Load miss handler: tracks outstanding load-miss blocks, issues LOAD requests
// on the shared memory port and broadcasts each fill to the load queue.
module load_miss_handler #(
  parameter int unsigned MSHR_SIZE = 4,
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 miss_req_valid,
  input  logic [63:0]          miss_req_addr,
  output logic                 miss_req_ready,
  input  logic                 mem_grant,
  output logic [1:0]           proc2mem_command,
  output logic [63:0]          proc2mem_addr,
  input  logic [TAG_WIDTH-1:0] mem2proc_response,
  input  logic [63:0]          mem2proc_data,
  input  logic [TAG_WIDTH-1:0] mem2proc_tag,
  output logic                 lq_miss_valid,
  output logic [63:0]          lq_miss_addr,
  output logic [63:0]          lq_miss_data,
  output logic                 empty
);

  localparam int unsigned BLK_W = 61;
  localparam int unsigned IDX_W = (MSHR_SIZE > 1) ? $clog2(MSHR_SIZE) : 1;
  localparam logic [1:0]  CMD_NONE = 2'd0;
  localparam logic [1:0]  CMD_LOAD = 2'd1;

  typedef enum logic [1:0] {
    INVALID    = 2'd0,
    WAIT_ISSUE = 2'd1,
    WAIT_DATA  = 2'd2
  } slot_state_e;

  slot_state_e          state_q [MSHR_SIZE];
  slot_state_e          state_d [MSHR_SIZE];
  logic [BLK_W-1:0]     blk_q   [MSHR_SIZE];
  logic [BLK_W-1:0]     blk_d   [MSHR_SIZE];
  logic [TAG_WIDTH-1:0] tag_q   [MSHR_SIZE];
  logic [TAG_WIDTH-1:0] tag_d   [MSHR_SIZE];

  logic        lq_valid_q, lq_valid_d;
  logic [63:0] lq_addr_q, lq_addr_d;
  logic [63:0] lq_data_q, lq_data_d;

  logic [BLK_W-1:0] req_blk;
  logic             match;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             iss_found;
  logic [IDX_W-1:0] iss_idx;
  logic             cmp_found;
  logic [IDX_W-1:0] cmp_idx;
  logic             all_invalid;
  logic             issue_fire;
  logic             accept_alloc;
  logic [2:0]       unused_addr_bits;

  assign req_blk          = miss_req_addr[63:3];
  assign unused_addr_bits = miss_req_addr[2:0];

  // Slot lookups on registered state; descending scan so the lowest index wins.
  always_comb begin
    match       = 1'b0;
    free_found  = 1'b0;
    free_idx    = '0;
    iss_found   = 1'b0;
    iss_idx     = '0;
    cmp_found   = 1'b0;
    cmp_idx     = '0;
    all_invalid = 1'b1;
    for (int i = MSHR_SIZE - 1; i >= 0; i--) begin
      if (state_q[i] != INVALID) begin
        all_invalid = 1'b0;
        if (blk_q[i] == req_blk) match = 1'b1;
      end
      if (state_q[i] == INVALID) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (state_q[i] == WAIT_ISSUE) begin
        iss_found = 1'b1;
        iss_idx   = IDX_W'(i);
      end
      if ((state_q[i] == WAIT_DATA) && (mem2proc_tag != '0) && (tag_q[i] == mem2proc_tag)) begin
        cmp_found = 1'b1;
        cmp_idx   = IDX_W'(i);
      end
    end
  end

  // Handshake and memory-port outputs are combinational in the request cycle.
  always_comb begin
    miss_req_ready   = reset && (match || free_found);
    accept_alloc     = reset && miss_req_valid && !match && free_found;
    issue_fire       = reset && mem_grant && iss_found;
    proc2mem_command = issue_fire ? CMD_LOAD : CMD_NONE;
    proc2mem_addr    = issue_fire ? {blk_q[iss_idx], 3'b000} : 64'd0;
  end

  assign empty         = all_invalid;
  assign lq_miss_valid = lq_valid_q;
  assign lq_miss_addr  = lq_addr_q;
  assign lq_miss_data  = lq_data_q;

  // Next-state: completion, issue and allocation always touch distinct slots.
  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    tag_d      = tag_q;
    lq_valid_d = 1'b0;
    lq_addr_d  = lq_addr_q;
    lq_data_d  = lq_data_q;
    if (cmp_found) begin
      state_d[cmp_idx] = INVALID;
      lq_valid_d       = 1'b1;
      lq_addr_d        = {blk_q[cmp_idx], 3'b000};
      lq_data_d        = mem2proc_data;
    end
    if (issue_fire && (mem2proc_response != '0)) begin
      state_d[iss_idx] = WAIT_DATA;
      tag_d[iss_idx]   = mem2proc_response;
    end
    if (accept_alloc) begin
      state_d[free_idx] = WAIT_ISSUE;
      blk_d[free_idx]   = req_blk;
      tag_d[free_idx]   = '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < MSHR_SIZE; i++) begin
        state_q[i] <= INVALID;
        blk_q[i]   <= '0;
        tag_q[i]   <= '0;
      end
      lq_valid_q <= 1'b0;
      lq_addr_q  <= 64'd0;
      lq_data_q  <= 64'd0;
    end else begin
      for (int i = 0; i < MSHR_SIZE; i++) begin
        state_q[i] <= state_d[i];
        blk_q[i]   <= blk_d[i];
        tag_q[i]   <= tag_d[i];
      end
      lq_valid_q <= lq_valid_d;
      lq_addr_q  <= lq_addr_d;
      lq_data_q  <= lq_data_d;
    end
  end

endmodule

// File: tb/tb_load_miss_handler.sv
// Self-checking bench for load_miss_handler: directed table, hand sequences,
// and randomized traffic against a slot-list reference model.
module tb_load_miss_handler;

  logic        clock;
  logic        reset;
  logic        miss_req_valid;
  logic [63:0] miss_req_addr;
  logic        miss_req_ready;
  logic        mem_grant;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic        lq_miss_valid;
  logic [63:0] lq_miss_addr;
  logic [63:0] lq_miss_data;
  logic        empty;

  load_miss_handler #(.MSHR_SIZE(4), .TAG_WIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .miss_req_valid(miss_req_valid), .miss_req_addr(miss_req_addr),
    .miss_req_ready(miss_req_ready), .mem_grant(mem_grant),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag), .lq_miss_valid(lq_miss_valid),
    .lq_miss_addr(lq_miss_addr), .lq_miss_data(lq_miss_data), .empty(empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: list of outstanding misses (sent = request got a tag).
  bit          m_valid [4];
  bit          m_sent  [4];
  logic [60:0] m_blk   [4];
  logic [3:0]  m_tag   [4];
  logic        m_lqv;
  logic [63:0] m_lqa, m_lqd;

  // Comb outputs observed in the most recent step.
  logic        obs_ready;
  logic [1:0]  obs_cmd;
  logic [63:0] obs_paddr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit tag_in_use(input logic [3:0] t);
    for (int i = 0; i < 4; i++)
      if (m_valid[i] && m_sent[i] && m_tag[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  // Expected handshake / memory request for the current inputs.
  task automatic model_comb(input logic rv, input logic [63:0] ra, input logic g,
                            output logic e_ready, output logic [1:0] e_cmd,
                            output logic [63:0] e_paddr);
    bit hit = 0, room = 0;
    int oldest_unsent = -1;
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i] && m_blk[i] == ra[63:3]) hit = 1;
      if (!m_valid[i]) room = 1;
    end
    for (int i = 3; i >= 0; i--)
      if (m_valid[i] && !m_sent[i]) oldest_unsent = i;
    e_ready = hit || room;
    e_cmd   = (g && oldest_unsent >= 0) ? 2'd1 : 2'd0;
    e_paddr = (oldest_unsent >= 0) ? {m_blk[oldest_unsent], 3'b000} : 64'd0;
  endtask

  // Model update at the clock edge, evaluated from the pre-edge model state.
  task automatic model_edge(input logic rst, input logic rv, input logic [63:0] ra,
                            input logic g, input logic [3:0] resp,
                            input logic [3:0] tg, input logic [63:0] dat);
    logic e_ready; logic [1:0] e_cmd; logic [63:0] e_paddr;
    int done = -1, send = -1, slot = -1;
    bit hit = 0;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        m_valid[i] = 0; m_sent[i] = 0; m_blk[i] = '0; m_tag[i] = '0;
      end
      m_lqv = 0; m_lqa = 0; m_lqd = 0;
      return;
    end
    model_comb(rv, ra, g, e_ready, e_cmd, e_paddr);
    for (int i = 0; i < 4; i++) begin
      if (tg != 0 && m_valid[i] && m_sent[i] && m_tag[i] == tg) done = i;
      if (m_valid[i] && m_blk[i] == ra[63:3]) hit = 1;
    end
    for (int i = 3; i >= 0; i--) begin
      if (m_valid[i] && !m_sent[i]) send = i;
      if (!m_valid[i]) slot = i;
    end
    m_lqv = (done >= 0);
    if (done >= 0) begin
      m_lqa = {m_blk[done], 3'b000};
      m_lqd = dat;
    end
    if (g && send >= 0 && resp != 0) begin
      m_sent[send] = 1; m_tag[send] = resp;
    end
    if (rv && !hit && slot >= 0) begin
      m_valid[slot] = 1; m_sent[slot] = 0; m_blk[slot] = ra[63:3]; m_tag[slot] = '0;
    end
    if (done >= 0) m_valid[done] = 0;
  endtask

  // One clock: drive at negedge, check comb outputs, clock, check registered outputs.
  task automatic step(input logic rst, input logic rv, input logic [63:0] ra,
                      input logic g, input logic [3:0] resp,
                      input logic [3:0] tg, input logic [63:0] dat);
    logic e_ready; logic [1:0] e_cmd; logic [63:0] e_paddr;
    bit e_empty;
    @(negedge clock);
    reset = rst; miss_req_valid = rv; miss_req_addr = ra; mem_grant = g;
    mem2proc_response = resp; mem2proc_tag = tg; mem2proc_data = dat;
    #1;
    obs_ready = miss_req_ready; obs_cmd = proc2mem_command; obs_paddr = proc2mem_addr;
    if (rst) begin
      model_comb(rv, ra, g, e_ready, e_cmd, e_paddr);
      chk("ready", 64'(miss_req_ready), 64'(e_ready));
      chk("cmd", 64'(proc2mem_command), 64'(e_cmd));
      if (e_cmd == 2'd1) chk("paddr", proc2mem_addr, e_paddr);
    end else begin
      chk("cmd_in_reset", 64'(proc2mem_command), 64'd0);
      chk("paddr_in_reset", proc2mem_addr, 64'd0);
    end
    @(posedge clock);
    model_edge(rst, rv, ra, g, resp, tg, dat);
    #1;
    e_empty = 1;
    for (int i = 0; i < 4; i++) if (m_valid[i]) e_empty = 0;
    chk("lq_valid", 64'(lq_miss_valid), 64'(m_lqv));
    chk("lq_addr", lq_miss_addr, m_lqa);
    chk("lq_data", lq_miss_data, m_lqd);
    chk("empty", 64'(empty), 64'(e_empty));
  endtask

  task automatic idle();
    step(1, 0, 64'd0, 0, 4'd0, 4'd0, 64'd0);
  endtask

  typedef struct {
    logic        rv;
    logic [63:0] ra;
    logic        g;
    logic [3:0]  resp;
    logic [3:0]  tg;
    logic [63:0] dat;
    logic        e_ready;
    logic [1:0]  e_cmd;
    logic [63:0] e_paddr;
    logic        e_lqv;
    logic [63:0] e_lqa;
    logic [63:0] e_lqd;
    logic        e_empty;
  } vec_t;

  localparam logic [63:0] DA = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] DB = 64'h0000_0000_0000_1234;
  vec_t vecs [13];

  initial begin
    // Single miss then a merged pair, from a freshly reset block.
    vecs[0]  = '{1, 64'h1004, 0, 0, 0, 0,  1, 1'b0, 0,        0, 0,       0,  0};
    vecs[1]  = '{0, 64'h0,    1, 3, 0, 0,  1, 2'd1, 64'h1000, 0, 0,       0,  0};
    vecs[2]  = '{0, 64'h0,    0, 0, 0, 0,  1, 2'd0, 0,        0, 0,       0,  0};
    vecs[3]  = '{0, 64'h0,    0, 0, 0, 0,  1, 2'd0, 0,        0, 0,       0,  0};
    vecs[4]  = '{0, 64'h0,    0, 0, 0, 0,  1, 2'd0, 0,        0, 0,       0,  0};
    vecs[5]  = '{0, 64'h0,    0, 0, 0, 0,  1, 2'd0, 0,        0, 0,       0,  0};
    vecs[6]  = '{0, 64'h0,    0, 0, 3, DA, 1, 2'd0, 0,        1, 64'h1000, DA, 1};
    vecs[7]  = '{0, 64'h0,    0, 0, 0, 0,  1, 2'd0, 0,        0, 64'h1000, DA, 1};
    vecs[8]  = '{1, 64'h2000, 0, 0, 0, 0,  1, 2'd0, 0,        0, 64'h1000, DA, 0};
    vecs[9]  = '{1, 64'h2004, 1, 4, 0, 0,  1, 2'd1, 64'h2000, 0, 64'h1000, DA, 0};
    vecs[10] = '{0, 64'h0,    1, 6, 0, 0,  1, 2'd0, 0,        0, 64'h1000, DA, 0};
    vecs[11] = '{0, 64'h0,    0, 0, 4, DB, 1, 2'd0, 0,        1, 64'h2000, DB, 1};
    vecs[12] = '{0, 64'h0,    0, 0, 0, 0,  1, 2'd0, 0,        0, 64'h2000, DB, 1};
  end

  initial begin
    reset = 0; miss_req_valid = 0; miss_req_addr = 0; mem_grant = 0;
    mem2proc_response = 0; mem2proc_tag = 0; mem2proc_data = 0;
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0; m_sent[i] = 0; m_blk[i] = '0; m_tag[i] = '0;
    end
    m_lqv = 0; m_lqa = 0; m_lqd = 0;

    // Reset for two cycles.
    step(0, 0, 64'd0, 0, 4'd0, 4'd0, 64'd0);
    step(0, 0, 64'd0, 0, 4'd0, 4'd0, 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_lqv", 64'(lq_miss_valid), 64'd0);

    // Directed table.
    foreach (vecs[k]) begin
      step(1, vecs[k].rv, vecs[k].ra, vecs[k].g, vecs[k].resp, vecs[k].tg, vecs[k].dat);
      chk($sformatf("v%0d_ready", k), 64'(obs_ready), 64'(vecs[k].e_ready));
      chk($sformatf("v%0d_cmd", k), 64'(obs_cmd), 64'(vecs[k].e_cmd));
      if (vecs[k].e_cmd == 2'd1) chk($sformatf("v%0d_paddr", k), obs_paddr, vecs[k].e_paddr);
      chk($sformatf("v%0d_lqv", k), 64'(lq_miss_valid), 64'(vecs[k].e_lqv));
      chk($sformatf("v%0d_lqa", k), lq_miss_addr, vecs[k].e_lqa);
      chk($sformatf("v%0d_lqd", k), lq_miss_data, vecs[k].e_lqd);
      chk($sformatf("v%0d_empty", k), 64'(empty), 64'(vecs[k].e_empty));
    end

    // Full: four blocks outstanding, fifth blocked until a completion frees a slot.
    step(1, 1, 64'h3000, 0, 0, 0, 0);
    step(1, 1, 64'h4000, 0, 0, 0, 0);
    step(1, 1, 64'h6000, 0, 0, 0, 0);
    step(1, 1, 64'h7000, 0, 0, 0, 0);
    step(1, 1, 64'h5000, 0, 0, 0, 0);
    chk("full_ready", 64'(obs_ready), 64'd0);
    step(1, 1, 64'h3000, 0, 0, 0, 0);
    chk("full_merge_ready", 64'(obs_ready), 64'd1);
    step(1, 1, 64'h5000, 1, 4'd1, 0, 0);
    chk("full_issue_cmd", 64'(obs_cmd), 64'd1);
    chk("full_issue_addr", obs_paddr, 64'h3000);
    step(1, 1, 64'h5000, 0, 0, 4'd1, 64'h55);
    chk("freed_same_cycle_ready", 64'(obs_ready), 64'd0);
    chk("full_fill_addr", lq_miss_addr, 64'h3000);
    step(1, 1, 64'h5000, 0, 0, 0, 0);
    chk("after_free_ready", 64'(obs_ready), 64'd1);

    // No grant, then a rejected issue, then an accepted retry.
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("nogrant_cmd", 64'(obs_cmd), 64'd0);
    end
    step(1, 0, 0, 1, 4'd0, 0, 0);
    chk("reject_cmd", 64'(obs_cmd), 64'd1);
    chk("reject_addr", obs_paddr, 64'h5000);
    step(1, 0, 0, 1, 4'd5, 0, 0);
    chk("retry_cmd", 64'(obs_cmd), 64'd1);
    chk("retry_addr", obs_paddr, 64'h5000);
    step(1, 0, 0, 1, 4'd9, 0, 0);
    chk("next_issue_addr", obs_paddr, 64'h4000);

    // Mid-operation reset drops everything; a late tag is ignored.
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 4'd5, 64'h77);
    chk("dropped_tag_lqv", 64'(lq_miss_valid), 64'd0);
    chk("dropped_empty", 64'(empty), 64'd1);

    // Out-of-order returns, merge into a completing slot, stray tag.
    step(1, 1, 64'h8000, 0, 0, 0, 0);
    step(1, 1, 64'h9000, 1, 4'd1, 0, 0);
    chk("ooo_issue_a", obs_paddr, 64'h8000);
    step(1, 0, 0, 1, 4'd2, 0, 0);
    chk("ooo_issue_b", obs_paddr, 64'h9000);
    step(1, 0, 0, 0, 0, 4'd2, 64'hB0B0);
    chk("ooo_first_addr", lq_miss_addr, 64'h9000);
    chk("ooo_first_data", lq_miss_data, 64'hB0B0);
    step(1, 1, 64'h8004, 0, 0, 4'd1, 64'hA0A0);
    chk("merge_completing_ready", 64'(obs_ready), 64'd1);
    chk("ooo_second_addr", lq_miss_addr, 64'h8000);
    step(1, 0, 0, 0, 0, 4'd7, 64'hDEAD);
    chk("stray_lqv", 64'(lq_miss_valid), 64'd0);
    chk("final_empty", 64'(empty), 64'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      logic rst, rv, g;
      logic [63:0] ra, dat;
      logic [3:0] resp, tg;
      logic [3:0] busy [$];
      int r;
      rst = ($urandom_range(0, 299) != 0);
      rv  = ($urandom_range(0, 2) != 0);
      ra  = 64'h0001_0000 + (64'($urandom_range(0, 5)) << 3) + 64'($urandom_range(0, 7));
      g   = ($urandom_range(0, 3) != 0);
      dat = {32'($urandom), 32'($urandom)};
      resp = 4'd0;
      if ($urandom_range(0, 3) != 0)
        do resp = 4'($urandom_range(1, 15)); while (tag_in_use(resp));
      busy.delete();
      for (int i = 0; i < 4; i++) if (m_valid[i] && m_sent[i]) busy.push_back(m_tag[i]);
      r  = $urandom_range(0, 99);
      tg = 4'd0;
      if (r < 40 && busy.size() > 0) tg = busy[$urandom_range(0, busy.size() - 1)];
      else if (r < 55) do tg = 4'($urandom_range(1, 15)); while (tag_in_use(tg));
      if (tg != 0 && tg == resp) resp = 4'd0;
      step(rst, rv, ra, g, resp, tg, dat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
